// File: rtl/jstk_paddle_tracker_pkg.sv
// Shared constants for the PmodJSTK paddle tracker: frame bit positions,
// joystick centre value, DIN command prefix and poll FSM state encodings.
package jstk_paddle_tracker_pkg;

  localparam int JSTK_CENTER = 512;

  // Y is split across the 40-bit frame: low byte in [23:16], high bits in [9:8]
  localparam int Y_LO_MSB = 23;
  localparam int Y_LO_LSB = 16;
  localparam int Y_HI_MSB = 9;
  localparam int Y_HI_LSB = 8;
  localparam int BTN_MSB  = 2;

  localparam logic [5:0] DIN_PREFIX = 6'b100000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_LATCH  = 3'd3,
    ST_UPDATE = 3'd4
  } poll_state_t;

  function automatic logic [9:0] extract_y(input logic [39:0] frame);
    return {frame[Y_HI_MSB:Y_HI_LSB], frame[Y_LO_MSB:Y_LO_LSB]};
  endfunction

endpackage

// File: rtl/jstk_paddle_tracker_poll_timer.sv
// Free-running poll counter plus the IDLE/SEND/WAIT/LATCH/UPDATE sequencer
// that drives PmodJSTK sndRec and tells the parent when to latch and update.
module jstk_paddle_tracker_poll_timer
  import jstk_paddle_tracker_pkg::*;
#(
  parameter int POLL_PERIOD = 125000,
  parameter int SND_HOLD    = 4,
  parameter int XFER_WAIT   = 20000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        snd_rec,
  output logic        latch_en,
  output logic        update_en,
  output poll_state_t state
);

  localparam int PCW     = $clog2(POLL_PERIOD);
  localparam int CNT_MAX = (XFER_WAIT > SND_HOLD) ? XFER_WAIT : SND_HOLD;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  logic [PCW-1:0] pc_q, pc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  poll_state_t    state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // The poll counter never waits on the FSM, so the poll rate stays fixed.
  always_comb begin
    pc_d    = (pc_q == PCW'(POLL_PERIOD - 1)) ? '0 : pc_q + PCW'(1);
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pc_q == '0) begin
          state_d = ST_SEND;
          cnt_d   = '0;
        end
      end
      ST_SEND: begin
        if (cnt_q == CW'(SND_HOLD - 1)) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == CW'(XFER_WAIT - 1)) begin
          state_d = ST_LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LATCH:  state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    snd_rec   = (state_q == ST_SEND);
    latch_en  = (state_q == ST_LATCH);
    update_en = (state_q == ST_UPDATE);
    state     = state_q;
  end

endmodule

// File: rtl/jstk_paddle_tracker.sv
// Per-player paddle tracker: polls a PmodJSTK, latches Y/buttons and integrates
// Y deflection into a clamped paddle position. JSTK_PADDLE_FILTER_EN adds a
// 4-sample moving average on Y.
module jstk_paddle_tracker
  import jstk_paddle_tracker_pkg::*;
#(
  parameter int POLL_PERIOD = 125000,
  parameter int SND_HOLD    = 4,
  parameter int XFER_WAIT   = 20000,
  parameter int PAD_MIN     = 0,
  parameter int PAD_MAX     = 400,
  parameter int PAD_INIT    = 200,
  parameter int DEADZONE    = 40,
  parameter int SPEED_SHIFT = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        freeze,
  input  logic [1:0]  led,
  input  logic [39:0] jstk_dout,
  output logic        snd_rec,
  output logic [7:0]  snd_data,
  output logic [9:0]  paddle_loc,
  output logic [2:0]  buttons,
  output logic        sample_valid,
  output poll_state_t dbg_state
);

  localparam logic signed [11:0] CENTER_S = 12'(JSTK_CENTER);
  localparam logic signed [11:0] DZ_S     = 12'(DEADZONE);
  localparam logic signed [11:0] MIN_S    = 12'(PAD_MIN);
  localparam logic signed [11:0] MAX_S    = 12'(PAD_MAX);

  logic latch_en, update_en;

  jstk_paddle_tracker_poll_timer #(
    .POLL_PERIOD (POLL_PERIOD),
    .SND_HOLD    (SND_HOLD),
    .XFER_WAIT   (XFER_WAIT)
  ) u_poll_timer (
    .clk       (clk),
    .reset     (reset),
    .snd_rec   (snd_rec),
    .latch_en  (latch_en),
    .update_en (update_en),
    .state     (dbg_state)
  );

  assign snd_data = {DIN_PREFIX, led};

  logic [9:0] y_eff;
  logic [9:0] y_new;
  assign y_new = extract_y(jstk_dout);

`ifdef JSTK_PADDLE_FILTER_EN
  logic [9:0]  hist_q [4];
  logic [9:0]  hist_d [4];
  logic [11:0] sum_q, sum_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= 10'(JSTK_CENTER);
      sum_q <= 12'(4 * JSTK_CENTER);
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
    end
  end

  // Running sum is adjusted by the entering and leaving samples only.
  always_comb begin
    hist_d = hist_q;
    sum_d  = sum_q;
    if (latch_en) begin
      hist_d[0] = y_new;
      for (int i = 1; i < 4; i++) hist_d[i] = hist_q[i-1];
      sum_d = sum_q + {2'b00, y_new} - {2'b00, hist_q[3]};
    end
  end

  assign y_eff = sum_q[11:2];

  logic unused_filter;
  assign unused_filter = ^sum_q[1:0];
`else
  logic [9:0] y_raw_q, y_raw_d;

  always_ff @(posedge clk) begin
    if (reset) y_raw_q <= 10'(JSTK_CENTER);
    else       y_raw_q <= y_raw_d;
  end

  always_comb begin
    y_raw_d = latch_en ? y_new : y_raw_q;
  end

  assign y_eff = y_raw_q;
`endif

  logic signed [11:0] off, step, nxt;
  logic [9:0]         pos;

  // Stick up (large y) gives a positive step, which moves the paddle toward row 0.
  always_comb begin
    off = $signed({2'b00, y_eff}) - CENTER_S;
    if ((off <= DZ_S) && (off >= -DZ_S)) step = '0;
    else                                  step = off >>> SPEED_SHIFT;
    nxt = $signed({2'b00, paddle_loc}) - step;
    if (nxt < MIN_S)      pos = 10'(PAD_MIN);
    else if (nxt > MAX_S) pos = 10'(PAD_MAX);
    else                  pos = nxt[9:0];
  end

  logic [9:0] paddle_q, paddle_d;
  logic [2:0] buttons_q, buttons_d;
  logic       sample_valid_q, sample_valid_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      paddle_q       <= 10'(PAD_INIT);
      buttons_q      <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      paddle_q       <= paddle_d;
      buttons_q      <= buttons_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  always_comb begin
    paddle_d       = (update_en && !freeze) ? pos : paddle_q;
    buttons_d      = latch_en ? jstk_dout[BTN_MSB:0] : buttons_q;
    sample_valid_d = update_en;
  end

  assign paddle_loc   = paddle_q;
  assign buttons      = buttons_q;
  assign sample_valid = sample_valid_q;

  logic unused_dout;
  assign unused_dout = ^{jstk_dout[39:24], jstk_dout[15:10], jstk_dout[7:3]};

endmodule

// File: tb/tb_jstk_paddle_tracker.sv
// Directed bench for jstk_paddle_tracker (default build, filter disabled) with
// shortened poll timing; a monitor pops expected {paddle, buttons} on each sample.
module tb_jstk_paddle_tracker;
  import jstk_paddle_tracker_pkg::*;

  localparam int POLL = 64;
  localparam int HOLD = 4;
  localparam int XW   = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        freeze;
  logic [1:0]  led;
  logic [39:0] jstk_dout;
  logic        snd_rec;
  logic [7:0]  snd_data;
  logic [9:0]  paddle_loc;
  logic [2:0]  buttons;
  logic        sample_valid;
  poll_state_t dbg_state;

  jstk_paddle_tracker #(
    .POLL_PERIOD (POLL),
    .SND_HOLD    (HOLD),
    .XFER_WAIT   (XW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .freeze       (freeze),
    .led          (led),
    .jstk_dout    (jstk_dout),
    .snd_rec      (snd_rec),
    .snd_data     (snd_data),
    .paddle_loc   (paddle_loc),
    .buttons      (buttons),
    .sample_valid (sample_valid),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  int n_samples = 0;
  logic [12:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [39:0] mk_dout(input logic [9:0] y, input logic [2:0] btn);
    logic [39:0] d;
    d        = '0;
    d[39:24] = 16'hA5C3;
    d[23:16] = y[7:0];
    d[15:10] = 6'b111111;
    d[9:8]   = y[9:8];
    d[7:3]   = 5'b10110;
    d[2:0]   = btn;
    return d;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && sample_valid) begin
      logic [12:0] e;
      n_samples++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sample: got paddle %0d, no sample expected", paddle_loc);
      end else begin
        e = exp_q.pop_front();
        check("sample_paddle", 32'(paddle_loc), 32'(e[12:3]));
        check("sample_buttons", 32'(buttons), 32'(e[2:0]));
      end
    end
  end

  // driver tasks
  task automatic wait_sample(input int base);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * POLL && !seen; i++) begin
      @(negedge clk);
      if (n_samples != base) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL poll_timeout: got no sample_valid within %0d cycles, required one", 3 * POLL);
      exp_q.delete();
    end
  endtask

  task automatic do_poll(input logic [9:0] y, input logic [2:0] btn, input logic frz, input int exp_p);
    int base;
    jstk_dout = mk_dout(y, btn);
    freeze    = frz;
    exp_q.push_back({10'(exp_p), btn});
    base = n_samples;
    wait_sample(base);
  endtask

  initial begin
    int p;
    int idx;
    int hi;
    int base;
    reset     = 1'b1;
    freeze    = 1'b0;
    led       = 2'b00;
    jstk_dout = mk_dout(10'd512, 3'b101);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_paddle", 32'(paddle_loc), 32'd200);
    check("reset_snd_rec", 32'(snd_rec), 32'd0);
    check("reset_buttons", 32'(buttons), 32'd0);
    check("reset_sample_valid", 32'(sample_valid), 32'd0);
    check("snd_data_led0", 32'(snd_data), 32'h80);

    // first poll: centred stick, snd_rec timing
    exp_q.push_back({10'd200, 3'b101});
    reset = 1'b0;
    idx = -1;
    for (int i = 0; i < POLL && idx < 0; i++) begin
      @(negedge clk);
      if (snd_rec) idx = i;
    end
    check("first_snd_rise_cycle", 32'(idx), 32'd0);
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (snd_rec) hi++;
      else break;
    end
    check("snd_rec_high_cycles", 32'(hi), 32'(HOLD));
    wait_sample(0);

    // full up: step 7 toward 0, clamp
    p = 200;
    repeat (31) begin
      p = p - 7;
      if (p < 0) p = 0;
      do_poll(10'd1023, 3'b011, 1'b0, p);
    end

    // full down: step -8, clamp at 400
    repeat (52) begin
      p = p + 8;
      if (p > 400) p = 400;
      do_poll(10'd0, 3'b100, 1'b0, p);
    end

    // deadzone edges and smallest non-zero steps
    do_poll(10'd552,  3'b001, 1'b0, 400);
    do_poll(10'd472,  3'b010, 1'b0, 400);
    do_poll(10'd1023, 3'b000, 1'b0, 393);
    do_poll(10'd448,  3'b110, 1'b0, 394);
    do_poll(10'd576,  3'b111, 1'b0, 393);
    do_poll(10'd552,  3'b101, 1'b0, 393);

    // freeze holds position, buttons still update
    do_poll(10'd1023, 3'b010, 1'b1, 393);
    do_poll(10'd0,    3'b111, 1'b1, 393);
    led = 2'b11;
    #1;
    check("snd_data_led3", 32'(snd_data), 32'h83);
    freeze = 1'b0;

    // reset in the middle of WAIT aborts the transfer
    jstk_dout = mk_dout(10'd0, 3'b110);
    idx = -1;
    for (int i = 0; i < 3 * POLL && idx < 0; i++) begin
      @(negedge clk);
      if (dbg_state == ST_WAIT) idx = i;
    end
    check("reached_wait", 32'(idx >= 0), 32'd1);
    repeat (10) @(negedge clk);
    check("mid_wait_state", 32'(dbg_state), 32'(ST_WAIT));
    base = n_samples;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_paddle", 32'(paddle_loc), 32'd200);
    check("abort_snd_rec", 32'(snd_rec), 32'd0);
    check("abort_buttons", 32'(buttons), 32'd0);
    check("abort_no_sample", 32'(n_samples), 32'(base));
    do_poll(10'd0, 3'b110, 1'b0, 208);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jstk_paddle_tracker.md
Name: jstk_paddle_tracker

Overview:
- Sits between one PmodJSTK instance and game_controller; one instance per player (A = left paddle, B = right paddle).
- Polls the PmodJSTK periodically using its sndRec/DIN/DOUT interface.
- Latches the 40-bit joystick frame, extracts Y and button bits, and integrates Y deflection into a clamped 10-bit paddle position for game_controller.

Parameters:
- POLL_PERIOD, 125000, clk cycles between poll starts (10 ms at 12.5 MHz).
- SND_HOLD, 4, cycles snd_rec is held high.
- XFER_WAIT, 20000, cycles after snd_rec falls before DOUT is latched.
- PAD_MIN, 0, minimum paddle_loc.
- PAD_MAX, 400, maximum paddle_loc (480 minus paddle height 80).
- PAD_INIT, 200, paddle_loc after reset.
- DEADZONE, 40, magnitude of Y offset from centre treated as zero.
- SPEED_SHIFT, 6, arithmetic right shift applied to offset to form the step.

Ports:
- clk  in  1  system clock (same clk as PmodJSTK/VGA).
- reset  in  1  synchronous, active-high reset.
- freeze  in  1  when high, polling continues but paddle_loc holds.
- led  in  2  LED request bits sent to the joystick.
- jstk_dout  in  40  PmodJSTK DOUT.
- snd_rec  out  1  PmodJSTK sndRec.
- snd_data  out  8  PmodJSTK DIN = {6'b100000, led}.
- paddle_loc  out  10  paddle top Y coordinate.
- buttons  out  3  latched jstk_dout[2:0].
- sample_valid  out  1  one-cycle pulse when a new sample has been applied.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: snd_rec=0, paddle_loc=PAD_INIT, buttons=0, sample_valid=0, state=IDLE, counters=0.
- Reset mid-operation (any state) aborts the transfer on the next clk edge; no latch, no position change.
- FSM states: IDLE, SEND, WAIT, LATCH, UPDATE.
  - Poll counter pc runs free from 0 to POLL_PERIOD-1 and wraps.
  - IDLE: go to SEND when pc==0.
  - SEND: snd_rec=1 for exactly SND_HOLD cycles, then WAIT.
  - WAIT: snd_rec=0; stay XFER_WAIT cycles, then LATCH.
  - LATCH: register jstk_dout. Extract y = {dout[9:8], dout[23:16]} and buttons = dout[2:0]. Go to UPDATE.
  - UPDATE: apply the position rule, pulse sample_valid, go to IDLE.
- Poll timing: one poll every POLL_PERIOD cycles. Requirement: POLL_PERIOD > SND_HOLD + XFER_WAIT + 2. The poll rate is not affected by the state machine.
- Position rule, computed in signed 12 bits:
  - off = y - 512.
  - If |off| <= DEADZONE: step = 0. Otherwise step = off >>> SPEED_SHIFT.
  - next = paddle_loc - step (stick up moves the paddle toward screen top).
  - Clamp: next < PAD_MIN gives PAD_MIN; next > PAD_MAX gives PAD_MAX.
- freeze=1 in UPDATE: paddle_loc unchanged; buttons still update; sample_valid still pulses.
- snd_data is combinational from led, so LED changes take effect on the next poll.
- Latency: paddle_loc changes exactly SND_HOLD + XFER_WAIT + 2 cycles after the SEND entry edge.

Optional Feature:
- Macro: JSTK_PADDLE_FILTER_EN.
- Defined: y passes through a 4-sample moving average before the offset is computed. A 4-entry shift register plus a 12-bit running sum, result = sum >> 2. All entries reset to 512. One sample enters per LATCH.
- Undefined: the raw y from LATCH is used directly; no filter registers exist.

Decomposition:
- Shared package/include (constants.vh): JSTK centre value 512, Y/button bit-slice positions, FSM state encodings, DIN command prefix 6'b100000.
- One natural sub-module: jstk_poll_timer, containing the poll counter, SEND/WAIT sequencing and the snd_rec generation. The parent keeps the latch, the position arithmetic and the filter.

Test Plan:
- Reset behaviour: reset held 3 cycles, then released -> paddle_loc=200, snd_rec=0, and the first snd_rec rise on the cycle pc reaches 0; snd_rec high for exactly 4 cycles.
- Centred stick: jstk_dout with y=512, buttons=3'b101 -> after one poll, paddle_loc=200, buttons=101, one sample_valid pulse.
- Full up: y=1023 repeated (off=511, step=7) -> paddle_loc 193, 186, …; clamps at 0 and stays there.
- Full down and deadzone: y=0 (step=-8) -> paddle_loc climbs by 8 per poll and clamps at 400. Then y=552 (off=40, inside deadzone) -> no change.
- freeze=1 with y=1023 -> paddle_loc constant; buttons and sample_valid still update every poll. led=2'b11 -> snd_data=8'b10000011.
- Reset mid-WAIT: reset asserted 100 cycles into WAIT -> no sample_valid pulse, paddle_loc=200, next poll proceeds normally. With JSTK_PADDLE_FILTER_EN defined, a step from y=512 to y=1023 ramps the filtered y through 639, 767, 895, 1023.
